// File: rtl/ws2812b_decoder.sv
// WS2812b single-wire receiver: classifies high-pulse widths into bits,
// assembles words MSB first and detects the latch (reset) low period.
module ws2812b_decoder #(
  parameter int LED_DATA_BUS_WIDTH    = 24,
  parameter int LED_ADDRESS_BUS_WIDTH = 24,
  parameter int MIN_HIGH_CYC          = 4,
  parameter int THRESH_CYC            = 28,
  parameter int MAX_HIGH_CYC          = 62,
  parameter int RESET_DET_CYC         = 1875
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             din,
  output logic [LED_DATA_BUS_WIDTH-1:0]    data_out,
  output logic                             data_valid,
  output logic [LED_ADDRESS_BUS_WIDTH-1:0] led_index,
  output logic                             frame_done,
  output logic [LED_ADDRESS_BUS_WIDTH-1:0] frame_leds,
  output logic                             error,
  output logic                             idle
);

  localparam int DW = LED_DATA_BUS_WIDTH;
  localparam int AW = LED_ADDRESS_BUS_WIDTH;
  localparam int HW = $clog2(MAX_HIGH_CYC + 2);
  localparam int LW = $clog2(RESET_DET_CYC + 1);
  localparam int BW = (DW > 1) ? $clog2(DW) : 1;

  localparam logic [HW-1:0] H_MIN  = HW'(MIN_HIGH_CYC);
  localparam logic [HW-1:0] H_THR  = HW'(THRESH_CYC);
  localparam logic [HW-1:0] H_MAX  = HW'(MAX_HIGH_CYC);
  localparam logic [HW-1:0] H_SAT  = HW'(MAX_HIGH_CYC + 1);
  localparam logic [LW-1:0] L_DET  = LW'(RESET_DET_CYC);
  localparam logic [BW-1:0] B_LAST = BW'(DW - 1);

  typedef enum logic [1:0] {WAIT_RESET, IDLE, HIGH, LOW} state_t;

  state_t          state_q, state_d;
  logic [1:0]      sync_q, sync_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic [LW-1:0]   lcnt_q, lcnt_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [AW-1:0]   word_cnt_q, word_cnt_d;
  logic [DW-1:0]   shift_q, shift_d;
  logic [DW-1:0]   data_out_q, data_out_d;
  logic [AW-1:0]   led_index_q, led_index_d;
  logic [AW-1:0]   frame_leds_q, frame_leds_d;
  logic            data_valid_q, data_valid_d;
  logic            frame_done_q, frame_done_d;
  logic            error_q, error_d;

  logic s;
  logic bit_val;

  assign s       = sync_q[1];
  assign bit_val = (hcnt_q >= H_THR);

  always_comb begin
    sync_d       = {sync_q[0], din};
    // Run-length counters track the synchronized line in every state.
    hcnt_d       = s ? ((hcnt_q == H_SAT) ? hcnt_q : hcnt_q + 1'b1) : '0;
    lcnt_d       = s ? '0 : ((lcnt_q == L_DET) ? lcnt_q : lcnt_q + 1'b1);
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    word_cnt_d   = word_cnt_q;
    shift_d      = shift_q;
    data_out_d   = data_out_q;
    led_index_d  = led_index_q;
    frame_leds_d = frame_leds_q;
    data_valid_d = 1'b0;
    frame_done_d = 1'b0;
    error_d      = 1'b0;

    case (state_q)
      WAIT_RESET: begin
        bit_cnt_d  = '0;
        word_cnt_d = '0;
        if (lcnt_d == L_DET) state_d = IDLE;
      end
      IDLE: begin
        bit_cnt_d  = '0;
        word_cnt_d = '0;
        if (s) state_d = HIGH;
      end
      HIGH: begin
        if (s) begin
          if (hcnt_q >= H_MAX) begin
            error_d = 1'b1;
            state_d = WAIT_RESET;
          end
        end else if (hcnt_q < H_MIN) begin
          error_d = 1'b1;
          state_d = WAIT_RESET;
        end else begin
          shift_d = {shift_q[DW-2:0], bit_val};
          state_d = LOW;
          if (bit_cnt_q == B_LAST) begin
            data_out_d   = shift_d;
            led_index_d  = word_cnt_q;
            data_valid_d = 1'b1;
            word_cnt_d   = word_cnt_q + 1'b1;
            bit_cnt_d    = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      LOW: begin
        if (s) begin
          state_d = HIGH;
        end else if (lcnt_d == L_DET) begin
          // Latch period: close the frame; a dangling partial word is flagged.
          frame_done_d = 1'b1;
          frame_leds_d = word_cnt_q;
          error_d      = (bit_cnt_q != '0);
          bit_cnt_d    = '0;
          word_cnt_d   = '0;
          state_d      = IDLE;
        end
      end
      default: state_d = WAIT_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= WAIT_RESET;
      sync_q       <= '0;
      hcnt_q       <= '0;
      lcnt_q       <= '0;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      shift_q      <= '0;
      data_out_q   <= '0;
      led_index_q  <= '0;
      frame_leds_q <= '0;
      data_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      hcnt_q       <= hcnt_d;
      lcnt_q       <= lcnt_d;
      bit_cnt_q    <= bit_cnt_d;
      word_cnt_q   <= word_cnt_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      led_index_q  <= led_index_d;
      frame_leds_q <= frame_leds_d;
      data_valid_q <= data_valid_d;
      frame_done_q <= frame_done_d;
      error_q      <= error_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign led_index  = led_index_q;
  assign frame_done = frame_done_q;
  assign frame_leds = frame_leds_q;
  assign error      = error_q;
  assign idle       = (state_q == IDLE);

endmodule

// File: tb/tb_ws2812b_decoder.sv
// Bench for ws2812b_decoder: pulse-level stimulus, a pulse-level reference
// model, a boundary-width vector table and directed multi-cycle sequences.
module tb_ws2812b_decoder;
  localparam int DW = 24, AW = 24, MINH = 4, THR = 28, MAXH = 62, R = 1875;

  logic          clk = 1'b0;
  logic          reset, din;
  logic [DW-1:0] data_out;
  logic          data_valid, frame_done, error, idle;
  logic [AW-1:0] led_index, frame_leds;

  ws2812b_decoder #(
    .LED_DATA_BUS_WIDTH(DW), .LED_ADDRESS_BUS_WIDTH(AW), .MIN_HIGH_CYC(MINH),
    .THRESH_CYC(THR), .MAX_HIGH_CYC(MAXH), .RESET_DET_CYC(R)
  ) dut (
    .clk(clk), .reset(reset), .din(din), .data_out(data_out),
    .data_valid(data_valid), .led_index(led_index), .frame_done(frame_done),
    .frame_leds(frame_leds), .error(error), .idle(idle)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed output events, one entry per pulse cycle (kind 0=word, 1=frame, 2=error)
  typedef struct {int kind; logic [23:0] val; logic [23:0] idx; int cyc;} ev_t;
  ev_t ev_q[$];
  ev_t exp_q[$];

  always @(negedge clk) begin
    ev_t e;
    if (data_valid) begin
      e.kind = 0; e.val = data_out; e.idx = led_index; e.cyc = cyc; ev_q.push_back(e);
    end
    if (frame_done) begin
      e.kind = 1; e.val = frame_leds; e.idx = 24'h0; e.cyc = cyc; ev_q.push_back(e);
    end
    if (error) begin
      e.kind = 2; e.val = 24'h0; e.idx = 24'h0; e.cyc = cyc; ev_q.push_back(e);
    end
  end

  int checks = 0, passes = 0;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Stimulus is a list of high/low pulse pairs; h==0 means a bare low.
  typedef struct {int h; int l;} pulse_t;
  pulse_t pq[$];
  int last_fall;

  function automatic void add_pulse(input int h, input int l);
    pulse_t p;
    p.h = h; p.l = l;
    pq.push_back(p);
  endfunction
  function automatic void add_bit(input logic b);
    if (b) add_pulse(41, 22);
    else   add_pulse(16, 47);
  endfunction
  function automatic void add_word(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) add_bit(w[i]);
  endfunction
  function automatic void add_low(input int n);
    pulse_t p;
    if (pq.size() == 0) begin
      add_pulse(0, n);
    end else begin
      p = pq.pop_back();
      p.l += n;
      pq.push_back(p);
    end
  endfunction

  // Reference model at the pulse level: widths classify bits, long lows end frames.
  logic        m_wait;
  int          m_bits, m_words;
  logic [23:0] m_shift;

  function automatic void push_exp(input int k, input logic [23:0] v, input logic [23:0] ix);
    ev_t e;
    e.kind = k; e.val = v; e.idx = ix; e.cyc = 0;
    exp_q.push_back(e);
  endfunction

  function automatic void model_pulse(input pulse_t p);
    logic in_frame;
    in_frame = 1'b0;
    if (p.h > 0 && !m_wait) begin
      if (p.h > MAXH || p.h < MINH) begin
        push_exp(2, 24'h0, 24'h0);
        m_wait = 1'b1;
      end else begin
        in_frame = 1'b1;
        m_shift  = {m_shift[22:0], (p.h >= THR)};
        m_bits++;
        if (m_bits == 24) begin
          push_exp(0, m_shift, m_words[23:0]);
          m_words++;
          m_bits = 0;
        end
      end
    end
    if (p.l >= R) begin
      if (in_frame) begin
        push_exp(1, m_words[23:0], 24'h0);
        if (m_bits != 0) push_exp(2, 24'h0, 24'h0);
      end
      m_wait  = 1'b0;
      m_bits  = 0;
      m_words = 0;
    end
  endfunction

  function automatic void model_reset();
    m_wait = 1'b1; m_bits = 0; m_words = 0; m_shift = 24'h0;
  endfunction

  task automatic drive(input logic lv, input int n);
    din = lv;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic play();
    foreach (pq[i]) begin
      model_pulse(pq[i]);
      if (pq[i].h > 0) drive(1'b1, pq[i].h);
      last_fall = cyc;
      drive(1'b0, pq[i].l);
    end
    pq.delete();
  endtask

  task automatic check_model(input string name);
    $display("[%s] events seen=%0d expected=%0d", name, ev_q.size(), exp_q.size());
    chk({name, "_count"}, ev_q.size(), exp_q.size());
    for (int i = 0; i < ev_q.size() && i < exp_q.size(); i++)
      chk(name, {4'(ev_q[i].kind), ev_q[i].val, ev_q[i].idx},
                {4'(exp_q[i].kind), exp_q[i].val, exp_q[i].idx});
    ev_q.delete();
    exp_q.delete();
  endtask

  task automatic check_zero_outputs(input string name);
    chk({name, "_data"},  data_out, 24'h0);
    chk({name, "_idx"},   led_index, 24'h0);
    chk({name, "_leds"},  frame_leds, 24'h0);
    chk({name, "_flags"}, {data_valid, frame_done, error, idle}, 4'b0000);
  endtask

  typedef struct {int msb_high; int exp_dv; logic [23:0] exp_data; int exp_err; int exp_fd;} vec_t;
  vec_t vt[6];

  initial begin
    int n_dv, n_err, n_fd;
    logic [23:0] got_data;
    int bnd[4];
    logic [22:0] rest;

    rest = 23'h35A5C3;
    vt[0] = '{27, 1, 24'h35A5C3, 0, 1};
    vt[1] = '{28, 1, 24'hB5A5C3, 0, 1};
    vt[2] = '{62, 1, 24'hB5A5C3, 0, 1};
    vt[3] = '{63, 0, 24'h0,      1, 0};
    vt[4] = '{4,  1, 24'h35A5C3, 0, 1};
    vt[5] = '{3,  0, 24'h0,      1, 0};
    bnd = '{4, 27, 28, 62};

    din = 1'b0;
    reset = 1'b1;
    model_reset();
    repeat (4) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    reset = 1'b0;

    // Single word with driver timing, then latency checks
    add_low(3000);
    play();
    chk("idle_after_sync", idle, 1'b1);
    add_word(24'hA5C30F);
    add_low(3125);
    play();
    chk("t1_events", ev_q.size(), 2);
    if (ev_q.size() == 2) begin
      chk("t1_word",    {ev_q[0].kind[3:0], ev_q[0].val, ev_q[0].idx}, {4'd0, 24'hA5C30F, 24'h0});
      chk("t1_dv_lat",  ev_q[0].cyc, last_fall + 3);
      chk("t1_frame",   {ev_q[1].kind[3:0], ev_q[1].val}, {4'd1, 24'h1});
      chk("t1_fd_lat",  ev_q[1].cyc, last_fall + R + 2);
    end
    chk("t1_leds_held", frame_leds, 24'h1);
    check_model("single_word");

    // Three back-to-back words
    add_word(24'h000001);
    add_word(24'hFFFFFF);
    add_word(24'h800000);
    add_low(1900);
    play();
    chk("three_leds", frame_leds, 24'h3);
    check_model("three_words");

    // Boundary high widths on the MSB of a word
    foreach (vt[v]) begin
      chk("vec_idle", idle, 1'b1);
      add_pulse(vt[v].msb_high, 47);
      for (int i = 22; i >= 0; i--) add_bit(rest[i]);
      add_low(1900);
      play();
      n_dv = 0; n_err = 0; n_fd = 0; got_data = 24'h0;
      foreach (ev_q[i]) begin
        if (ev_q[i].kind == 0) begin n_dv++; got_data = ev_q[i].val; end
        if (ev_q[i].kind == 1) n_fd++;
        if (ev_q[i].kind == 2) n_err++;
      end
      $display("vec high=%0d dv=%0d err=%0d fd=%0d data=%06h", vt[v].msb_high, n_dv, n_err, n_fd, got_data);
      chk("vec_dv",  n_dv,  vt[v].exp_dv);
      chk("vec_err", n_err, vt[v].exp_err);
      chk("vec_fd",  n_fd,  vt[v].exp_fd);
      if (vt[v].exp_dv == 1) chk("vec_data", got_data, vt[v].exp_data);
      ev_q.delete();
      exp_q.delete();
    end

    // Glitch mid-word, then recovery after a full low and a fresh frame
    for (int i = 0; i < 5; i++) add_bit(1'b1);
    add_pulse(2, 47);
    for (int i = 0; i < 8; i++) add_bit(i[0]);
    add_low(1900);
    add_word(24'h0F0F0F);
    add_low(1900);
    play();
    check_model("glitch");

    // Ten bits then latch period: frame_done and error together
    for (int i = 0; i < 10; i++) add_bit(i[1]);
    add_low(R);
    play();
    chk("partial_events", ev_q.size(), 2);
    if (ev_q.size() == 2) begin
      chk("partial_same_cyc", ev_q[1].cyc, ev_q[0].cyc);
      chk("partial_leds", ev_q[0].val, 24'h0);
    end
    check_model("partial");

    // Reset in the middle of bit 12
    add_word(24'h123456);
    add_low(1900);
    play();
    check_model("pre_reset");
    for (int i = 0; i < 11; i++) add_bit(i[0]);
    play();
    drive(1'b1, 10);
    reset = 1'b1;
    drive(1'b1, 1);
    check_zero_outputs("mid_reset");
    reset = 1'b0;
    model_reset();
    add_pulse(30, 22);
    for (int i = 0; i < 12; i++) add_bit(i[1]);
    add_low(1900);
    add_word(24'hC0FFEE);
    add_low(1900);
    play();
    check_model("post_reset");

    // Randomized pulse trains against the model
    for (int f = 0; f < 4; f++) begin
      int np, r, h, l;
      np = $urandom_range(8, 20);
      for (int p = 0; p < np; p++) begin
        r = $urandom_range(0, 99);
        if (r < 4)       h = $urandom_range(1, MINH - 1);
        else if (r < 7)  h = $urandom_range(MAXH + 1, MAXH + 8);
        else if (r < 15) h = bnd[$urandom_range(0, 3)];
        else             h = $urandom_range(MINH, MAXH);
        r = $urandom_range(0, 99);
        if (r < 3)       l = R - 1;
        else if (r < 6)  l = R;
        else             l = $urandom_range(5, 60);
        add_pulse(h, l);
      end
      add_low(R + 10);
      play();
      check_model("random");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
